uart_rx_module: RTL and testbench

//   Receive side of the RS232 UART link: 8N1 serial in, 16x oversampled, bytes

---
 rtl/uart_rx_module.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_module.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_module.sv
// uart_rx_module: 16x-oversampled UART receiver (8N1) feeding a registered-read byte FIFO.
// Define RX_PARITY_EN to receive 8E1 frames and raise parity_err on even-parity mismatch.
module uart_rx_module #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_req,
    output logic [7:0] data,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int DIV     = CLK_FREQ / (BAUD * 16);
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int PW      = FIFO_AW + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t state, state_nxt;

    logic          rx_meta, rx_sync;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    sample_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          bit_sample;
    logic          mid_start;
    logic          parity_ok;

    // FSM output decodes
    logic shift_en, stop_smp, wr_en, frame_err_c, parity_err_c;
`ifdef RX_PARITY_EN
    logic par_bit, par_en;
`endif

    assign tick       = (tick_cnt == TICK_LAST);
    assign bit_sample = tick && (sample_cnt == 4'd15);
    assign mid_start  = (state == START) && tick && (sample_cnt == 4'd7);

`ifdef RX_PARITY_EN
    assign parity_ok = ~(^shift ^ par_bit);
`else
    assign parity_ok = 1'b1;
`endif

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // update together on the edge; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!rx_sync) state_nxt = START;
            START: if (mid_start) state_nxt = rx_sync ? IDLE : DATA;
`ifdef RX_PARITY_EN
            DATA:   if (bit_sample && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY: if (bit_sample) state_nxt = STOP;
`else
            DATA:   if (bit_sample && bit_cnt == 3'd7) state_nxt = STOP;
`endif
            STOP:  if (bit_sample) state_nxt = rx_sync ? IDLE : BREAK;
            BREAK: if (rx_sync) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: each output gets a default before the decode so no latch is inferred.
    always_comb begin
        shift_en     = 1'b0;
        stop_smp     = 1'b0;
        wr_en        = 1'b0;
        frame_err_c  = 1'b0;
        parity_err_c = 1'b0;
`ifdef RX_PARITY_EN
        par_en       = 1'b0;
`endif
        unique case (state)
            DATA: shift_en = bit_sample;
`ifdef RX_PARITY_EN
            PARITY: par_en = bit_sample;
`endif
            STOP: begin
                stop_smp     = bit_sample;
                frame_err_c  = bit_sample && !rx_sync;
                parity_err_c = bit_sample && rx_sync && !parity_ok;
                wr_en        = bit_sample && rx_sync && parity_ok;
            end
            default: ;
        endcase
    end

    // Synchronizer, oversampling counters and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            tick_cnt   <= '0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
`ifdef RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;

            if (state == IDLE || tick) tick_cnt <= '0;
            else                       tick_cnt <= TW'(tick_cnt + 1'b1);

            if (state == IDLE || mid_start) sample_cnt <= '0;
            else if (tick)                  sample_cnt <= 4'(sample_cnt + 4'd1);

            if (state == IDLE || mid_start) bit_cnt <= '0;
            else if (shift_en)              bit_cnt <= 3'(bit_cnt + 3'd1);

            if (shift_en) shift <= {rx_sync, shift[7:1]};
`ifdef RX_PARITY_EN
            if (par_en) par_bit <= rx_sync;
`endif
        end
    end

    // Byte FIFO: extra pointer MSB distinguishes full from empty
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic          rd_ok, wr_ok, overrun_c;

    assign rd_ok      = rd_req && !fifo_empty;
    assign wr_ok      = wr_en && (!fifo_full || rd_req);
    assign overrun_c  = wr_en && fifo_full && !rd_req;
    assign wr_ptr_nxt = PW'(wr_ptr + PW'(wr_ok));
    assign rd_ptr_nxt = PW'(rd_ptr + PW'(rd_ok));

    // NOTE: the storage array is deliberately not reset; the pointers alone define
    // which entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[FIFO_AW-1:0]] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data       <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            if (rd_ok) data <= mem[rd_ptr[FIFO_AW-1:0]];
            fifo_empty <= (wr_ptr_nxt == rd_ptr_nxt);
            fifo_full  <= (wr_ptr_nxt[FIFO_AW-1:0] == rd_ptr_nxt[FIFO_AW-1:0]) &&
                          (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]);
            frame_err  <= frame_err_c;
            overrun    <= overrun_c;
            parity_err <= parity_err_c;
        end
    end

    // stop_smp is kept as a named decode for readability in waveforms
    logic unused_ok;
    assign unused_ok = stop_smp;

endmodule

// File: tb/tb_uart_rx_module.sv
// tb_uart_rx_module: scoreboard bench for uart_rx_module; bytes expected in the FIFO
// are queued as frames are sent and compared as they are read back.
module tb_uart_rx_module;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 390_625;       // DIV = 8 keeps the run short
    localparam int DEPTH    = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * 16);
    localparam int BIT      = DIV * 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_req = 1'b0;
    logic [7:0] data;
    logic       fifo_empty, fifo_full, frame_err, overrun, parity_err;

    uart_rx_module #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_req(rd_req), .data(data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .frame_err(frame_err),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold_rx(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
    endtask

    // Drive one frame; good frames are pushed to the scoreboard if the FIFO has room
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        hold_rx(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold_rx(b[i], BIT);
`ifdef RX_PARITY_EN
        hold_rx(^b ^ par_flip, BIT);
`endif
        hold_rx(stop_bit, BIT);
        if (stop_bit && !par_flip && exp_q.size() < DEPTH) exp_q.push_back(b);
    endtask

    task automatic do_read(input string tag);
        logic [7:0] exp;
        @(negedge clk) rd_req = 1'b1;
        @(negedge clk) rd_req = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, data, exp);
        end
    endtask

    initial begin
        int fe0, ov0, pe0, waited;

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("rst_data",  data, 8'h00);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full",  fifo_full, 1'b0);
        check("rst_pulses", {frame_err, overrun, parity_err}, 3'b000);
        hold_rx(1'b1, BIT);

        // 1: single byte
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        send_frame(8'h21, 1'b1, 1'b0);
        waited = 0;
        while (fifo_empty && waited < 10 * BIT) begin
            @(negedge clk);
            waited++;
        end
        check("t1_nonempty", fifo_empty, 1'b0);
        do_read("t1_data");
        check("t1_empty", fifo_empty, 1'b1);
        check("t1_errs", fe_cnt + ov_cnt + pe_cnt, fe0 + ov0 + pe0);
        @(negedge clk) rd_req = 1'b1;
        @(negedge clk) rd_req = 1'b0;
        check("t1_rd_empty_hold", data, 8'h21);
        check("t1_rd_empty_flag", fifo_empty, 1'b1);

        // 2: glitch shorter than half a bit
        fe0 = fe_cnt;
        hold_rx(1'b0, BIT / 4);
        hold_rx(1'b1, 4 * BIT);
        check("t2_empty", fifo_empty, 1'b1);
        check("t2_no_fe", fe_cnt, fe0);

        // 3: framing error followed by a long break, then recovery
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        hold_rx(1'b0, 2000);
        check("t3_one_fe", fe_cnt - fe0, 1);
        check("t3_empty", fifo_empty, 1'b1);
        hold_rx(1'b1, 2 * BIT);
        send_frame(8'h5A, 1'b1, 1'b0);
        do_read("t3_data");

        // 4: fill to full, overflow once, drain in order
        ov0 = ov_cnt;
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            if (i == 15) check("t4_full", fifo_full, 1'b1);
        end
        hold_rx(1'b1, BIT);
        check("t4_overrun", ov_cnt - ov0, 1);
        check("t4_still_full", fifo_full, 1'b1);
        for (int i = 0; i < 16; i++) do_read($sformatf("t4_rd%0d", i));
        check("t4_empty", fifo_empty, 1'b1);
        check("t4_not_full", fifo_full, 1'b0);

        // 5: reset in the middle of bit 4 with a byte already buffered
        send_frame(8'h3C, 1'b1, 1'b0);
        hold_rx(1'b0, BIT);
        hold_rx(1'b1, 4 * BIT + BIT / 2);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
        check("t5_data",  data, 8'h00);
        check("t5_empty", fifo_empty, 1'b1);
        check("t5_full",  fifo_full, 1'b0);
        check("t5_pulses", {frame_err, overrun, parity_err}, 3'b000);
        hold_rx(1'b1, 6 * BIT);
        send_frame(8'hA5, 1'b1, 1'b0);
        do_read("t5_data_after");
        check("t5_empty_after", fifo_empty, 1'b1);

`ifdef RX_PARITY_EN
        // 6: parity mismatch discards the byte; correct parity delivers it
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h03, 1'b1, 1'b1);
        hold_rx(1'b1, BIT);
        check("t6_pe", pe_cnt - pe0, 1);
        check("t6_no_fe", fe_cnt - fe0, 0);
        check("t6_empty", fifo_empty, 1'b1);
        send_frame(8'h03, 1'b1, 1'b0);
        do_read("t6_data");
        check("t6_pe_once", pe_cnt - pe0, 1);
`else
        check("parity_tied", pe_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        repeat (90_000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 90000 cycles");
        $fatal(1);
    end

endmodule
